uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receiver. Watches the serial line and the edge/bit counter outputs, and drives the enables for the counter, bit sampler, deserializer and the start/parity/stop checkers. Asserts data_valid for exactly one clock when a frame passes every check. Sits in the UART_RX top between the line input and the datapath sub-blocks.

---
 rtl/uart_rx_fsm.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// Frame-sequencing controller for the UART receiver: walks start, data, optional
// parity and stop bits, gates the datapath checkers and flags accepted or aborted frames.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic [5:0] prescale,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       cnt_enable,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
  } state_t;

  localparam logic [3:0] DATA_IDX = 4'(DATA_WIDTH);
  localparam logic [3:0] PAR_IDX  = 4'(DATA_WIDTH + 1);

  state_t     state;
  logic       par_en_lat;
  logic       last_edge;
  logic [3:0] stop_idx;

  // edge_cnt is zero-extended so prescale=32 compares against 31 without truncation
  assign last_edge = ({1'b0, edge_cnt} == (prescale - 6'd1));
  assign stop_idx  = PAR_IDX + {3'b000, par_en_lat};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      par_en_lat    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state      <= START;
            par_en_lat <= par_en;
          end
        end
        START: begin
          if (bit_cnt == 4'd0 && last_edge)
            state <= strt_glitch ? IDLE : DATA;
        end
        DATA: begin
          if (bit_cnt == DATA_IDX && last_edge)
            state <= par_en_lat ? PARITY : STOP;
        end
        PARITY: begin
          if (bit_cnt == PAR_IDX && last_edge) begin
            if (par_err) begin
              state        <= IDLE;
              parity_error <= 1'b1;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (bit_cnt == stop_idx && last_edge) begin
            if (stp_err) begin
              state         <= IDLE;
              framing_error <= 1'b1;
            end else begin
              state <= VALID;
            end
          end
        end
        VALID: begin
          // a start edge right after the stop bit chains straight into the next frame
          if (!rx_in) begin
            state      <= START;
            par_en_lat <= par_en;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_enable  = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      START: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
      end
      DATA: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = last_edge;
      end
      PARITY: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
      end
      STOP: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // VALID holds cnt_enable low for its single cycle, clearing the counter for the next frame
  assign data_valid = (state == VALID);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a frame-position model predicts every output each cycle
// under directed and randomized frames, with literal pulse counts pinning the model.
module tb_uart_rx_fsm;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [4:0] edge_cnt = 5'd0;
  logic [3:0] bit_cnt = 4'd0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, parity_error, framing_error, busy;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
    .parity_error(parity_error), .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // model: a frame is just a cycle offset k from its first START cycle
  int  P = 8;
  bit  m_in_frame, m_valid, m_perr, m_ferr, m_pe;
  int  m_k;
  bit  plan_gl, plan_pe, plan_se;
  bit  rand_mode, pe_toggle, pe_cfg, gl_cfg, pr_cfg, se_cfg;
  int  starts_left;
  logic [7:0]  cfg_data, next_data;
  logic [10:0] serial;
  int  checks = 0, passes = 0, cyc = 0;
  int  n_dv, n_deser, n_perr, n_ferr, n_stpchk, n_parchk, n_busy;

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clr_counts();
    n_dv = 0; n_deser = 0; n_perr = 0; n_ferr = 0; n_stpchk = 0; n_parchk = 0; n_busy = 0;
  endtask

  task automatic start_frame();
    logic [7:0] d;
    m_in_frame = 1'b1;
    m_k        = 0;
    m_pe       = par_en;
    if (starts_left > 0) starts_left--;
    if (rand_mode) begin
      d       = 8'($urandom);
      plan_gl = ($urandom_range(0, 7) == 0);
      plan_pe = ($urandom_range(0, 7) == 0);
      plan_se = ($urandom_range(0, 7) == 0);
    end else begin
      d         = cfg_data;
      cfg_data  = next_data;
      plan_gl   = gl_cfg;
      plan_pe   = pr_cfg;
      plan_se   = se_cfg;
    end
    serial = m_pe ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
  endtask

  task automatic model_step();
    int b, e, sidx;
    bit last;
    if (!rst_n) begin
      m_in_frame = 1'b0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
      m_pe = 1'b0; m_k = 0;
      return;
    end
    m_perr = 1'b0;
    m_ferr = 1'b0;
    if (m_in_frame) begin
      b    = m_k / P;
      e    = m_k % P;
      last = (e == P - 1);
      sidx = DW + 1 + int'(m_pe);
      if (last && b == 0 && strt_glitch) m_in_frame = 1'b0;
      else if (last && m_pe && b == DW + 1 && par_err) begin
        m_in_frame = 1'b0; m_perr = 1'b1;
      end else if (last && b == sidx) begin
        m_in_frame = 1'b0;
        if (stp_err) m_ferr = 1'b1;
        else m_valid = 1'b1;
      end else m_k++;
    end else begin
      m_valid = 1'b0;
      if (!rx_in) start_frame();
    end
  endtask

  task automatic drive();
    int b, e;
    bit last;
    prescale = 6'(P);
    b = m_in_frame ? m_k / P : 0;
    e = m_in_frame ? m_k % P : 0;
    bit_cnt  = 4'(b);
    edge_cnt = 5'(e);
    last = m_in_frame && (e == P - 1);
    par_en = pe_toggle ? 1'($urandom_range(0, 1)) : pe_cfg;
    strt_glitch = ($urandom_range(0, 3) == 0);
    par_err     = ($urandom_range(0, 3) == 0);
    stp_err     = ($urandom_range(0, 3) == 0);
    if (last && b == 0) strt_glitch = plan_gl;
    if (last && m_pe && b == DW + 1) par_err = plan_pe;
    if (last && b == DW + 1 + int'(m_pe)) stp_err = plan_se;
    if (m_in_frame) rx_in = rand_mode ? 1'($urandom_range(0, 1)) : serial[b];
    else if (rand_mode) rx_in = ($urandom_range(0, 2) != 0);
    else rx_in = (starts_left > 0) ? 1'b0 : 1'b1;
    if (rand_mode) rst_n = ($urandom_range(0, 599) != 0);
  endtask

  task automatic compare();
    logic [9:0] ev, av;
    int b, e;
    bit inf, last;
    inf  = m_in_frame;
    b    = m_k / P;
    e    = m_k % P;
    last = inf && (e == P - 1);
    ev[9] = inf;
    ev[8] = inf;
    ev[7] = last && b >= 1 && b <= DW;
    ev[6] = inf && b == 0;
    ev[5] = inf && m_pe && b == DW + 1;
    ev[4] = inf && b == DW + 1 + int'(m_pe);
    ev[3] = m_valid;
    ev[2] = m_perr;
    ev[1] = m_ferr;
    ev[0] = inf || m_valid;
    av = {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
          data_valid, parity_error, framing_error, busy};
    checks++;
    if (av === ev) passes++;
    else $display("FAIL outputs cycle %0d {cnt,samp,deser,strt,par,stp,dv,perr,ferr,busy}: got %b, expected %b",
                  cyc, av, ev);
    if (data_valid)    n_dv++;
    if (deser_en)      n_deser++;
    if (parity_error)  n_perr++;
    if (framing_error) n_ferr++;
    if (stp_chk_en)    n_stpchk++;
    if (par_chk_en)    n_parchk++;
    if (busy)          n_busy++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      drive();
      #4;
      compare();
      cyc++;
    end
  endtask

  function automatic int outs_word();
    return int'({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                 data_valid, parity_error, framing_error, busy});
  endfunction

  initial begin
    bit reached;
    rand_mode = 0; pe_toggle = 0; pe_cfg = 0; gl_cfg = 0; pr_cfg = 0; se_cfg = 0;
    starts_left = 0; cfg_data = 8'h00; next_data = 8'h00;
    run(3);
    rst_n = 1'b1;
    check_lit("reset_state", outs_word(), 0);

    // 0xA5, prescale 8, no parity
    P = 8; pe_cfg = 0; cfg_data = 8'hA5; next_data = 8'hA5;
    run(2); clr_counts(); starts_left = 1; run(90);
    check_lit("a5_deser", n_deser, 8);
    check_lit("a5_valid", n_dv, 1);
    check_lit("a5_errors", n_perr + n_ferr, 0);
    check_lit("a5_busy_cycles", n_busy, 81);

    // 0x3C with parity, prescale 16, then a start glitch
    P = 16; pe_cfg = 1; cfg_data = 8'h3C; next_data = 8'h3C;
    run(2); clr_counts(); starts_left = 1; run(190);
    check_lit("3c_valid", n_dv, 1);
    check_lit("3c_parchk_cycles", n_parchk, 16);
    check_lit("3c_busy_cycles", n_busy, 177);
    gl_cfg = 1; clr_counts(); starts_left = 1; run(30);
    check_lit("glitch_deser", n_deser, 0);
    check_lit("glitch_valid", n_dv, 0);
    check_lit("glitch_errors", n_perr + n_ferr, 0);
    check_lit("glitch_busy_cycles", n_busy, 16);
    gl_cfg = 0;

    // parity abort, prescale 8
    P = 8; pe_cfg = 1; pr_cfg = 1;
    run(2); clr_counts(); starts_left = 1; run(95);
    check_lit("perr_pulses", n_perr, 1);
    check_lit("perr_stpchk", n_stpchk, 0);
    check_lit("perr_valid", n_dv, 0);
    check_lit("perr_busy_cycles", n_busy, 80);
    pr_cfg = 0;

    // framing abort at prescale 32, then a good 0xFF frame
    P = 32; pe_cfg = 0; se_cfg = 1;
    run(2); clr_counts(); starts_left = 1; run(330);
    check_lit("ferr_pulses", n_ferr, 1);
    check_lit("ferr_valid", n_dv, 0);
    se_cfg = 0; cfg_data = 8'hFF; next_data = 8'hFF;
    clr_counts(); starts_left = 1; run(330);
    check_lit("ff_valid", n_dv, 1);
    check_lit("ff_errors", n_perr + n_ferr, 0);

    // back-to-back 0x00 then 0x81
    P = 8; pe_cfg = 0; cfg_data = 8'h00; next_data = 8'h81;
    run(2); clr_counts(); starts_left = 2; run(175);
    check_lit("b2b_valid", n_dv, 2);
    check_lit("b2b_deser", n_deser, 16);
    check_lit("b2b_busy_cycles", n_busy, 162);

    // reset mid-DATA at bit 4, par_en toggling throughout
    pe_toggle = 1; starts_left = 1; reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      run(1);
      reached = m_in_frame && (m_k / P == 4);
    end
    check_lit("reach_bit4", int'(reached), 1);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    check_lit("mid_reset_outputs", outs_word(), 0);
    clr_counts(); starts_left = 1; run(100);
    check_lit("after_reset_valid", n_dv, 1);
    check_lit("after_reset_deser", n_deser, 8);

    // randomized segments over all prescales
    for (int seg = 0; seg < 6; seg++) begin
      rand_mode = 0; starts_left = 0; rst_n = 1'b1;
      for (int i = 0; i < 500 && (m_in_frame || m_valid); i++) run(1);
      check_lit("quiesce", int'(m_in_frame || m_valid), 0);
      case ($urandom_range(0, 2))
        0: P = 8;
        1: P = 16;
        default: P = 32;
      endcase
      run(1);
      rand_mode = 1;
      run(1500);
    end
    rand_mode = 0; rst_n = 1'b1; starts_left = 0;
    run(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
